// File: rtl/dec_entry_to_bin_pkg.sv
// dec_entry_to_bin_pkg: shared states, digit width and segment patterns; DIGIT_W follows SEG_INPUT_EN.
package dec_entry_to_bin_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  localparam int DEC_RADIX = 10;
`ifdef SEG_INPUT_EN
  localparam int DIGIT_W = 7;
`else
  localparam int DIGIT_W = 4;
`endif
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
endpackage

// File: rtl/dec_entry_to_bin_seg7_to_bcd.sv
// seg7_to_bcd: combinational 7-segment (a..g = bit6..bit0) to BCD decode with legal flag.
// Only built when SEG_INPUT_EN is defined.
`ifdef SEG_INPUT_EN
module seg7_to_bcd
  import dec_entry_to_bin_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_digit,
  output logic       o_legal
);
  always_comb begin
    o_digit = 4'd0;
    o_legal = 1'b1;
    case (i_seg)
      SEG_0: o_digit = 4'd0;
      SEG_1: o_digit = 4'd1;
      SEG_2: o_digit = 4'd2;
      SEG_3: o_digit = 4'd3;
      SEG_4: o_digit = 4'd4;
      SEG_5: o_digit = 4'd5;
      SEG_6: o_digit = 4'd6;
      SEG_7: o_digit = 4'd7;
      SEG_8: o_digit = 4'd8;
      SEG_9: o_digit = 4'd9;
      default: o_legal = 1'b0;
    endcase
  end
endmodule
`endif

// File: rtl/dec_entry_to_bin.sv
// dec_entry_to_bin: accumulates decimal digits MSD-first into a saturating binary value with valid/ready output.
// SEG_INPUT_EN selects 7-segment digit input instead of BCD.
module dec_entry_to_bin
  import dec_entry_to_bin_pkg::*;
#(
  parameter int MAX_DIGITS = 5,
  parameter int OUT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit_in,
  output logic               digit_ready,
  input  logic               enter,
  input  logic               clear,
  output logic               bin_valid,
  input  logic               bin_ready,
  output logic [OUT_W-1:0]   binary_num,
  output logic [2:0]         ndigits,
  output logic               overflow,
  output logic               err_digit
);
  state_t           r_state, w_state_nx;
  logic [OUT_W-1:0] r_acc, r_bin, w_acc_dig;
  logic [OUT_W+3:0] w_next;
  logic [2:0]       r_nd, w_nd_dig;
  logic [3:0]       w_d;
  logic             r_ovf, r_err, w_legal, w_open, w_accept, w_rej, w_sat, w_ovf_dig;
`ifdef SEG_INPUT_EN
  seg7_to_bcd u_dec (.i_seg(digit_in), .o_digit(w_d), .o_legal(w_legal));
`else
  assign w_d     = digit_in;
  assign w_legal = digit_in < 4'(DEC_RADIX);
`endif
  // acc*10 + d with headroom so the saturation test sees the true value
  assign w_next    = ({4'b0, r_acc} << 3) + ({4'b0, r_acc} << 1) + (OUT_W+4)'(w_d);
  assign w_sat     = w_next > {4'b0, {OUT_W{1'b1}}};
  assign w_open    = r_state != HOLD;
  assign w_accept  = w_open && digit_valid && w_legal && (r_nd < 3'(MAX_DIGITS));
  assign w_rej     = w_open && digit_valid && !w_accept;
  assign w_acc_dig = !w_accept ? r_acc : w_sat ? {OUT_W{1'b1}} : w_next[OUT_W-1:0];
  assign w_nd_dig  = r_nd + 3'(w_accept);
  assign w_ovf_dig = r_ovf | (w_accept & w_sat);
  always_comb begin
    w_state_nx = clear ? IDLE :
                 r_state == HOLD ? (bin_ready ? IDLE : HOLD) :
                 enter ? HOLD : w_accept ? ACCUM : r_state;
  end
  always_ff @(posedge clk) begin
    r_state <= rst ? IDLE : w_state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
      r_nd  <= '0;
      r_ovf <= 1'b0;
      r_bin <= '0;
      r_err <= 1'b0;
    end else if (clear || (r_state == HOLD && bin_ready)) begin
      r_acc <= '0;
      r_nd  <= '0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
    end else if (w_open) begin
      r_acc <= w_acc_dig;
      r_nd  <= w_nd_dig;
      r_ovf <= w_ovf_dig;
      r_err <= w_rej;
      if (enter) r_bin <= w_acc_dig;
    end else begin
      r_err <= 1'b0;
    end
  end
  assign digit_ready = w_open;
  assign bin_valid   = r_state == HOLD;
  assign binary_num  = r_bin;
  assign ndigits     = r_nd;
  assign overflow    = r_ovf;
  assign err_digit   = r_err;
endmodule

// File: tb/tb_dec_entry_to_bin.sv
// tb_dec_entry_to_bin: directed scoreboard bench for the BCD-input build.
module tb_dec_entry_to_bin;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit_in = 4'd0;
  logic        digit_ready;
  logic        enter = 1'b0;
  logic        clear = 1'b0;
  logic        bin_valid;
  logic        bin_ready = 1'b0;
  logic [15:0] binary_num;
  logic [2:0]  ndigits;
  logic        overflow;
  logic        err_digit;
  int          checks = 0;
  int          errors = 0;
  int          m_acc = 0;
  int          m_nd = 0;
  bit          m_ovf = 1'b0;
  typedef struct {int v; int nd; bit ov;} exp_t;
  exp_t        q[$];

  dec_entry_to_bin dut (
    .clk(clk), .rst(rst), .digit_valid(digit_valid), .digit_in(digit_in),
    .digit_ready(digit_ready), .enter(enter), .clear(clear), .bin_valid(bin_valid),
    .bin_ready(bin_ready), .binary_num(binary_num), .ndigits(ndigits),
    .overflow(overflow), .err_digit(err_digit)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_nd = 0;
    m_ovf = 1'b0;
  endtask

  task automatic collect(input string tag);
    exp_t e;
    for (int i = 0; i < 8 && !bin_valid; i++) tick();
    chk({tag, "_valid"}, bin_valid, 1);
    if (q.size() == 0) begin
      chk({tag, "_sb_empty"}, q.size(), 1);
    end else begin
      e = q.pop_front();
      chk({tag, "_num"}, binary_num, e.v);
      chk({tag, "_nd"}, ndigits, e.nd);
      chk({tag, "_ovf"}, overflow, e.ov);
    end
  endtask

  // Drive one digit (optionally with enter), update the decimal model, check err_digit.
  task automatic dig(input string tag, input int d, input bit en);
    bit ok;
    int n;
    digit_valid = 1'b1;
    digit_in = d[3:0];
    enter = en;
    ok = (d <= 9) && (m_nd < 5);
    if (ok) begin
      n = m_acc * 10 + d;
      if (n > 65535) begin
        n = 65535;
        m_ovf = 1'b1;
      end
      m_acc = n;
      m_nd++;
    end
    if (en) q.push_back('{m_acc, m_nd, m_ovf});
    tick();
    digit_valid = 1'b0;
    enter = 1'b0;
    chk({tag, "_err"}, err_digit, !ok);
    if (en) begin
      chk({tag, "_latency"}, bin_valid, 1);
      collect(tag);
    end
  endtask

  task automatic commit(input string tag);
    enter = 1'b1;
    q.push_back('{m_acc, m_nd, m_ovf});
    tick();
    enter = 1'b0;
    chk({tag, "_latency"}, bin_valid, 1);
    collect(tag);
  endtask

  task automatic accept(input string tag);
    bin_ready = 1'b1;
    tick();
    bin_ready = 1'b0;
    model_reset();
    chk({tag, "_bv"}, bin_valid, 0);
    chk({tag, "_rdy"}, digit_ready, 1);
    chk({tag, "_nd"}, ndigits, 0);
    chk({tag, "_ovf"}, overflow, 0);
  endtask

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("rst_num", binary_num, 0);
    chk("rst_bv", bin_valid, 0);
    chk("rst_nd", ndigits, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_err", err_digit, 0);
    chk("rst_rdy", digit_ready, 1);

    foreach (q[i]) q.delete(i);
    dig("d1", 1, 0); dig("d2", 2, 0); dig("d3", 3, 0); dig("d4", 4, 0); dig("d5", 5, 0);
    commit("c12345");
    chk("c12345_const", binary_num, 16'h3039);
    accept("a12345");

    dig("s6", 6, 0); dig("s5", 5, 0); dig("s5b", 5, 0); dig("s3", 3, 0); dig("s6b", 6, 0);
    chk("sat_ovf", overflow, 1);
    dig("sixth", 1, 0);
    chk("sixth_nd", ndigits, 5);
    tick();
    chk("sixth_pulse_end", err_digit, 0);
    commit("csat");
    chk("csat_const", binary_num, 16'hFFFF);
    accept("asat");

    dig("seven", 7, 0);
    dig("illegal", 10, 0);
    chk("illegal_nd", ndigits, 1);
    tick();
    chk("illegal_pulse_end", err_digit, 0);
    dig("illegal15", 15, 0);
    commit("c7");
    accept("a7");

    dig("four", 4, 0);
    dig("two_enter", 2, 1);
    chk("c42_const", binary_num, 16'h002A);
    for (int i = 0; i < 3; i++) begin
      digit_valid = 1'b1;
      digit_in = 4'd9;
      enter = 1'b1;
      tick();
      chk("hold_num", binary_num, 16'h002A);
      chk("hold_rdy", digit_ready, 0);
      chk("hold_err", err_digit, 0);
      chk("hold_bv", bin_valid, 1);
      chk("hold_nd", ndigits, 2);
    end
    digit_valid = 1'b0;
    enter = 1'b0;
    accept("a42");
    chk("a42_keep", binary_num, 16'h002A);

    dig("three", 3, 0);
    commit("c3");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_reset();
    chk("clr_bv", bin_valid, 0);
    chk("clr_nd", ndigits, 0);
    dig("nine", 9, 0);
    commit("c9a");
    accept("a9a");

    dig("r6", 6, 0); dig("r5", 5, 0); dig("r5b", 5, 0); dig("r3", 3, 0); dig("r6b", 6, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("mrst_num", binary_num, 0);
    chk("mrst_nd", ndigits, 0);
    chk("mrst_ovf", overflow, 0);
    dig("nine2", 9, 0);
    commit("c9b");
    accept("a9b");

    commit("c_empty");
    chk("c_empty_nd", ndigits, 0);
    accept("a_empty");

    digit_valid = 1'b1;
    digit_in = 4'd12;
    clear = 1'b1;
    tick();
    digit_valid = 1'b0;
    clear = 1'b0;
    chk("clr_err", err_digit, 0);
    bin_ready = 1'b1;
    tick();
    bin_ready = 1'b0;
    chk("idle_ready_bv", bin_valid, 0);
    chk("sb_drained", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
